// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential signed multiply-add, result = quotient*divisor + remainder.
// Radix-2 shift-add, one multiplier bit per clock, valid/ready on both sides.
// Optional build macro MUL_ADD_SEQ_CHECK_EN adds dividend_i / mismatch_o, which
// compare the rebuilt result against the dividend supplied with the operands.
module mul_add_seq #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef MUL_ADD_SEQ_CHECK_EN
  input  logic [N-1:0]         dividend_i,
  output logic                 mismatch_o,
`endif
  input  logic [N-1:0]         quotient_i,
  input  logic [M-1:0]         divisor_i,
  input  logic [M-1:0]         remainder_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [N+M:0]         result_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int P  = N + M + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  mplier;     // quotient, shifted right one bit per iteration
  logic [P-1:0]  mcand;      // sign-extended divisor, shifted left one bit per iteration
  logic [P-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [P-1:0]  addend;
  logic [P-1:0]  acc_next;
  logic          last_iter;

`ifdef MUL_ADD_SEQ_CHECK_EN
  logic [N-1:0]  dividend;
  logic [P-1:0]  dividend_ext;
`endif

  // Ready only from the registered idle state, and never while reset is held.
  assign ready_o = (state == IDLE) && !rst_i;

  // One shift-add step: the multiplier MSB carries negative weight, so it subtracts.
  always_comb begin
    last_iter = (cnt == LAST);
    addend    = {P{1'b0}};
    acc_next  = acc;
    if (mplier[0]) begin
      addend = mcand;
    end else begin
      addend = {P{1'b0}};
    end
    if (last_iter) begin
      acc_next = acc - addend;
    end else begin
      acc_next = acc + addend;
    end
  end

`ifdef MUL_ADD_SEQ_CHECK_EN
  // Sign-extend the captured dividend to the result width for comparison.
  always_comb begin
    dividend_ext = {{(P-N){dividend[N-1]}}, dividend};
  end
`endif

  // Control FSM and datapath: accept, iterate N times, hold result until taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      valid_o  <= 1'b0;
      result_o <= {P{1'b0}};
      cnt      <= {CW{1'b0}};
      acc      <= {P{1'b0}};
      mplier   <= {N{1'b0}};
      mcand    <= {P{1'b0}};
`ifdef MUL_ADD_SEQ_CHECK_EN
      dividend   <= {N{1'b0}};
      mismatch_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            mplier <= quotient_i;
            mcand  <= {{(P-M){divisor_i[M-1]}}, divisor_i};
            acc    <= {{(P-M){remainder_i[M-1]}}, remainder_i};
            cnt    <= {CW{1'b0}};
`ifdef MUL_ADD_SEQ_CHECK_EN
            dividend <= dividend_i;
`endif
            state  <= BUSY;
          end else begin
            state  <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          if (last_iter) begin
            cnt      <= {CW{1'b0}};
            state    <= DONE;
            valid_o  <= 1'b1;
            result_o <= acc_next;
`ifdef MUL_ADD_SEQ_CHECK_EN
            mismatch_o <= (acc_next != dividend_ext);
`endif
          end else begin
            cnt   <= cnt + CW'(1);
            state <= BUSY;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
`ifdef MUL_ADD_SEQ_CHECK_EN
            mismatch_o <= 1'b0;
`endif
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
`ifdef MUL_ADD_SEQ_CHECK_EN
          mismatch_o <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: directed and random checks of mul_add_seq against an
// arithmetic reference (q*d + r computed with integer math).
module tb_mul_add_seq;

  localparam int N = 8;
  localparam int M = 8;
  localparam int P = N + M + 1;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] quotient_i;
  logic [M-1:0] divisor_i;
  logic [M-1:0] remainder_i;
  logic         valid_i;
  logic         ready_o;
  logic [P-1:0] result_o;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] dividend_i;
`ifdef MUL_ADD_SEQ_CHECK_EN
  logic         mismatch_o;
`endif

  int checks = 0;
  int errors = 0;

  mul_add_seq #(.N(N), .M(M)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
`ifdef MUL_ADD_SEQ_CHECK_EN
    .dividend_i (dividend_i),
    .mismatch_o (mismatch_o),
`endif
    .quotient_i (quotient_i),
    .divisor_i  (divisor_i),
    .remainder_i(remainder_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation; hold = cycles ready_i stays low once the result is up.
  task automatic run_op(input logic [N-1:0] q, input logic [M-1:0] d, input logic [M-1:0] r,
                        input logic [N-1:0] dv, input int hold);
    int edges;
    int expv;
    logic [P-1:0] exp_p;
    expv  = $signed(q) * $signed(d) + $signed(r);
    exp_p = expv[P-1:0];
    check("ready_before_accept", {31'd0, ready_o}, 32'd1);
    quotient_i  = q;
    divisor_i   = d;
    remainder_i = r;
    dividend_i  = dv;
    valid_i     = 1'b1;
    ready_i     = (hold == 0);
    tick();
    // Inputs after the accept edge must be ignored.
    valid_i     = 1'b0;
    quotient_i  = N'($urandom);
    divisor_i   = M'($urandom);
    remainder_i = M'($urandom);
    dividend_i  = N'($urandom);
    edges = 0;
    while (!valid_o && edges < 40) begin
      tick();
      edges++;
    end
    check("latency", edges, N);
    check("result", {15'd0, result_o}, {15'd0, exp_p});
`ifdef MUL_ADD_SEQ_CHECK_EN
    check("mismatch", {31'd0, mismatch_o}, {31'd0, (expv != int'($signed(dv)))});
`endif
    for (int i = 0; i < hold; i++) begin
      valid_i     = 1'b1;
      quotient_i  = N'($urandom);
      tick();
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_result", {15'd0, result_o}, {15'd0, exp_p});
      check("hold_ready", {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    check("valid_drop", {31'd0, valid_o}, 32'd0);
    check("result_kept", {15'd0, result_o}, {15'd0, exp_p});
    check("ready_after", {31'd0, ready_o}, 32'd1);
`ifdef MUL_ADD_SEQ_CHECK_EN
    check("mismatch_clr", {31'd0, mismatch_o}, 32'd0);
`endif
  endtask

  initial begin
    int edges;
    int seen;
    int dvd;
    int dvs;
    int qq;
    int rr;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    quotient_i = '0; divisor_i = '0; remainder_i = '0; dividend_i = '0;
    tick();
    tick();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", {15'd0, result_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, ready_o}, 32'd1);

    // Directed cases.
    run_op(8'd5, 8'd7, 8'd3, 8'd38, 0);
    run_op(8'h80, 8'h80, 8'd127, 8'd0, 0);
    run_op(8'hFD, 8'd7, 8'hFE, 8'hE9, 0);
    run_op(8'd0, 8'hFB, 8'hFC, 8'hFC, 0);
    run_op(8'd9, 8'd0, 8'd11, 8'd11, 0);
    run_op(8'h7F, 8'h7F, 8'h80, 8'd0, 0);
    run_op(8'd100, 8'hC4, 8'd17, 8'd0, 5);

    // Reset during BUSY iteration 4.
    quotient_i = 8'd5; divisor_i = 8'd7; remainder_i = 8'd3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_i = 1'b1;
    #1;
    check("busy_rst_ready", {31'd0, ready_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("busy_rst_release_ready", {31'd0, ready_o}, 32'd1);
    check("busy_rst_result", {15'd0, result_o}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o) seen++;
      tick();
    end
    check("busy_rst_no_valid", seen, 0);

    // Random operands with random downstream stalls.
    for (int i = 0; i < 60; i++) begin
      run_op(N'($urandom), M'($urandom), M'($urandom), N'($urandom), int'($urandom_range(0, 3)));
    end

    // Operands taken from a divider model: dividend = q*d + r, with truncating division.
    for (int i = 0; i < 128; i++) begin
      dvd = int'($urandom_range(0, 255)) - 128;
      do begin
        dvs = int'($urandom_range(0, 255)) - 128;
      end while (dvs == 0 || (dvs == -1 && dvd == -128));
      qq = dvd / dvs;
      rr = dvd % dvs;
      if (i == 77) begin
        run_op(N'(qq), M'(rr == 0 ? dvs : dvs), M'(rr), N'(dvd + 1), 0);
      end else begin
        run_op(N'(qq), M'(dvs), M'(rr), N'(dvd), 0);
      end
    end

    // Back-to-back throughput: next accept possible N+2 edges after the previous one.
    quotient_i = 8'd3; divisor_i = 8'd4; remainder_i = 8'd1; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    edges = 1;
    while (!ready_o && edges < 40) begin
      tick();
      edges++;
    end
    check("throughput", edges, N + 2);
    valid_i = 1'b0;
    tick();
    edges = 0;
    while (!valid_o && edges < 40) begin
      tick();
      edges++;
    end
    check("b2b_result", {15'd0, result_o}, 32'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
